// File: rtl/pe_noc_pkg.sv
// Shared packet definitions for the PE / binary-tree switch network.
// Packet layout on the wire: {pad, dest, data}, dest starting at DEST_LSB.
package pe_noc_pkg;

    localparam int unsigned PKT_ADDR_W  = 2;
    localparam int unsigned PKT_DATA_W  = 32;
    localparam int unsigned PKT_TOTAL_W = 35;
    localparam int unsigned DEST_LSB    = PKT_DATA_W;

    typedef struct packed {
        logic [PKT_ADDR_W-1:0] dest;
        logic [PKT_DATA_W-1:0] data;
    } pkt_t;

    // Zero-extends a {dest, data} packet to the full wire width.
    function automatic logic [PKT_TOTAL_W-1:0] pack_pkt(input pkt_t p);
        return PKT_TOTAL_W'(p);
    endfunction

endpackage

// File: rtl/egress_fifo_mem.sv
// Purpose: Depth x Width packet storage, one write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data follows rd_addr combinationally.
// Backpressure: none here; the owner gates wr_en on its own full condition.
module egress_fifo_mem #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 35,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    // Storage carries no reset; validity is tracked by the owner's occupancy.
    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_egress_buffer.sv
// Purpose: elastic FWFT buffer from PE injection port to switch leaf; build option PE_EGRESS_BYPASS_EN.
// Latency: 1 cycle push-to-valid; 0 cycles through the idle bypass when PE_EGRESS_BYPASS_EN is defined.
// Backpressure: o_data_ready drops only when full, decoded from registered occupancy.
module pe_egress_buffer
    import pe_noc_pkg::*;
#(
    parameter int unsigned AddressWidth = PKT_ADDR_W,
    parameter int unsigned DataWidth    = PKT_DATA_W,
    parameter int unsigned TotalWidth   = PKT_TOTAL_W,
    parameter int unsigned FifoDepth    = 8,
    parameter int unsigned CountWidth   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TotalWidth-1:0]        i_data,
    input  logic                         i_data_valid,
    output logic                         o_data_ready,
    output logic [TotalWidth-1:0]        o_data,
    output logic                         o_data_valid,
    input  logic                         i_data_ready,
    output logic [AddressWidth-1:0]      o_dest,
    output logic [$clog2(FifoDepth):0]   o_occupancy,
    output logic [CountWidth-1:0]        o_pkt_count
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned OccW = PtrW + 1;
    localparam logic [OccW-1:0] OccFull = OccW'(FifoDepth);

    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       rd_ptr;
    logic [OccW-1:0]       occ;
    logic [CountWidth-1:0] pkt_cnt;
    logic                  rdy_en;
    logic                  mem_vld;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic [TotalWidth-1:0] rd_data;

    // rdy_en keeps ready low through reset and the release cycle.
    assign mem_vld      = (occ != '0);
    assign o_data_ready = rdy_en && (occ != OccFull);
    assign push         = i_data_valid && o_data_ready;
    assign pop          = mem_vld && i_data_ready;

`ifdef PE_EGRESS_BYPASS_EN
    logic byp_vld;

    // Idle buffer presents the incoming packet directly; it is stored only if the switch stalls.
    assign byp_vld      = !mem_vld && rdy_en && i_data_valid;
    assign wr_en        = push && !(byp_vld && i_data_ready);
    assign o_data_valid = mem_vld || byp_vld;
    assign o_data       = mem_vld ? rd_data : (byp_vld ? i_data : '0);
`else
    assign wr_en        = push;
    assign o_data_valid = mem_vld;
    assign o_data       = mem_vld ? rd_data : '0;
`endif

    assign o_dest      = o_data[DataWidth +: AddressWidth];
    assign o_occupancy = occ;
    assign o_pkt_count = pkt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            pkt_cnt <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (push) begin
                pkt_cnt <= pkt_cnt + CountWidth'(1);
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + OccW'(1);
                2'b01:   occ <= occ - OccW'(1);
                default: occ <= occ;
            endcase
        end
    end

    egress_fifo_mem #(
        .Depth (FifoDepth),
        .Width (TotalWidth)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pe_egress_buffer.sv
// Directed and randomized-stall bench for pe_egress_buffer with a queue scoreboard.
module tb_pe_egress_buffer;
    import pe_noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [34:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [34:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic [1:0]  o_dest;
    logic [3:0]  o_occupancy;
    logic [31:0] o_pkt_count;

    int errors  = 0;
    int checks  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pe_egress_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_dest       (o_dest),
        .o_occupancy  (o_occupancy),
        .o_pkt_count  (o_pkt_count)
    );

    function automatic logic [34:0] pk(input int k);
        pkt_t p;
        p.dest = 2'(k % 4);
        p.data = 32'(k);
        return pack_pkt(p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_data = '0; i_data_valid = 1'b0; i_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", o_data_ready); end
        checks++; if (o_data_valid !== 1'b0 || o_data !== '0 || o_dest !== '0) begin errors++; $display("FAIL rst_out got v=%b d=%h exp v=0 d=0", o_data_valid, o_data); end
        rst = 1'b0;
        step();
        checks++; if (o_data_ready !== 1'b1 || o_occupancy !== 4'd0 || o_pkt_count !== 32'd0) begin errors++; $display("FAIL rst_release got rdy=%b occ=%0d cnt=%0d exp 1/0/0", o_data_ready, o_occupancy, o_pkt_count); end
        // hold three packets, then reset mid-traffic
        for (int k = 0; k < 3; k++) begin
            i_data = pk(50 + k); i_data_valid = 1'b1;
            step();
        end
        i_data_valid = 1'b0;
        checks++; if (o_occupancy !== 4'd3) begin errors++; $display("FAIL pre_rst_occ got=%0d exp=3", o_occupancy); end
        rst = 1'b1;
        #1;
        checks++; if (o_data_valid !== 1'b0 || o_occupancy !== 4'd0 || o_pkt_count !== 32'd0 || o_data !== '0) begin errors++; $display("FAIL mid_rst got v=%b occ=%0d cnt=%0d d=%h exp 0/0/0/0", o_data_valid, o_occupancy, o_pkt_count, o_data); end
        #1 rst = 1'b0;
        step();
        checks++; if (o_data_ready !== 1'b1 || o_occupancy !== 4'd0) begin errors++; $display("FAIL mid_rst_release got rdy=%b occ=%0d exp 1/0", o_data_ready, o_occupancy); end
        exp_cnt = 0;
    endtask

    task automatic test_single();
        logic [34:0] p;
        p = {1'b0, 2'b10, 32'h0000_0005};
        i_data = p; i_data_valid = 1'b1; i_data_ready = 1'b1;
        #1;
`ifdef PE_EGRESS_BYPASS_EN
        checks++; if (o_data_valid !== 1'b1 || o_data !== p || o_dest !== 2'd2) begin errors++; $display("FAIL single_bypass got v=%b d=%h exp v=1 d=%h", o_data_valid, o_data, p); end
`else
        checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL single_no_comb got v=%b exp=0", o_data_valid); end
`endif
        step();
        i_data_valid = 1'b0;
        exp_cnt++;
`ifndef PE_EGRESS_BYPASS_EN
        #1;
        checks++; if (o_data_valid !== 1'b1 || o_data !== p || o_dest !== 2'd2 || o_occupancy !== 4'd1) begin errors++; $display("FAIL single_out got v=%b d=%h dest=%0d occ=%0d exp v=1 d=%h dest=2 occ=1", o_data_valid, o_data, o_dest, o_occupancy, p); end
`endif
        step();
        checks++; if (o_occupancy !== 4'd0 || o_data_valid !== 1'b0 || o_pkt_count !== 32'(exp_cnt)) begin errors++; $display("FAIL single_after got occ=%0d v=%b cnt=%0d exp 0/0/%0d", o_occupancy, o_data_valid, o_pkt_count, exp_cnt); end
    endtask

    task automatic test_fill();
        i_data_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_data = pk(k); i_data_valid = 1'b1;
            step();
            exp_cnt++;
        end
        checks++; if (o_data_ready !== 1'b0 || o_occupancy !== 4'd8) begin errors++; $display("FAIL fill_full got rdy=%b occ=%0d exp 0/8", o_data_ready, o_occupancy); end
        i_data = pk(99);
        step();
        checks++; if (o_occupancy !== 4'd8 || o_pkt_count !== 32'(exp_cnt)) begin errors++; $display("FAIL fill_ninth got occ=%0d cnt=%0d exp 8/%0d", o_occupancy, o_pkt_count, exp_cnt); end
        checks++; if (o_data_valid !== 1'b1 || o_data !== pk(0)) begin errors++; $display("FAIL fill_head got v=%b d=%h exp v=1 d=%h", o_data_valid, o_data, pk(0)); end
    endtask

    task automatic test_drain_wrap();
        int nxt = 8;
        int got = 0;
        logic popped, pushed;
        logic [34:0] pdat;
        i_data_ready = 1'b1;
        for (int c = 0; c < 100 && got < 21; c++) begin
            i_data_valid = (nxt <= 20);
            i_data = pk(nxt);
            #1;
            popped = o_data_valid; pushed = i_data_valid && o_data_ready; pdat = o_data;
            step();
            if (pushed) begin nxt++; exp_cnt++; end
            if (popped) begin
                checks++; if (pdat !== pk(got)) begin errors++; $display("FAIL drain_seq[%0d] got=%h exp=%h", got, pdat, pk(got)); end
                got++;
            end
        end
        i_data_valid = 1'b0;
        checks++; if (got !== 21) begin errors++; $display("FAIL drain_timeout got=%0d pops exp=21", got); end
        checks++; if (o_occupancy !== 4'd0 || o_pkt_count !== 32'(exp_cnt)) begin errors++; $display("FAIL drain_end got occ=%0d cnt=%0d exp 0/%0d", o_occupancy, o_pkt_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        i_data_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_data = pk(100 + k); i_data_valid = 1'b1;
            step();
            exp_cnt++;
        end
        checks++; if (o_occupancy !== 4'd4) begin errors++; $display("FAIL b2b_occ_start got=%0d exp=4", o_occupancy); end
        i_data_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_data = pk(104 + k);
            #1;
            checks++; if (o_data !== pk(100 + k)) begin errors++; $display("FAIL b2b_head[%0d] got=%h exp=%h", k, o_data, pk(100 + k)); end
            step();
            exp_cnt++;
            checks++; if (o_occupancy !== 4'd4 || o_pkt_count !== 32'(exp_cnt)) begin errors++; $display("FAIL b2b_occ[%0d] got occ=%0d cnt=%0d exp 4/%0d", k, o_occupancy, o_pkt_count, exp_cnt); end
        end
        i_data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (o_data_valid !== 1'b1 || o_data !== pk(105 + k)) begin errors++; $display("FAIL b2b_drain[%0d] got v=%b d=%h exp=%h", k, o_data_valid, o_data, pk(105 + k)); end
            step();
        end
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", o_occupancy); end
    endtask

    task automatic test_random_stall();
        logic [34:0] q[$];
        logic [34:0] exp_d, prev_dat;
        logic hold, prev_stall, push, pop;
        pkt_t p;
        hold = 1'b0; prev_stall = 1'b0; prev_dat = '0;
        for (int c = 0; c < 1000; c++) begin
            if (!hold) begin
                i_data_valid = ($urandom_range(0, 2) != 0);
                p.dest = 2'($urandom);
                p.data = $urandom;
                i_data = pack_pkt(p);
            end
            i_data_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                checks++; if (o_data_valid !== 1'b1 || o_data !== prev_dat) begin errors++; $display("FAIL stall_stable c=%0d got v=%b d=%h exp v=1 d=%h", c, o_data_valid, o_data, prev_dat); end
            end
            push = i_data_valid && o_data_ready;
            pop  = o_data_valid && i_data_ready;
            if (push) begin q.push_back(i_data); exp_cnt++; end
            if (pop) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rand_spurious c=%0d got d=%h exp no valid", c, o_data); end
                else begin
                    exp_d = q.pop_front();
                    if (o_data !== exp_d) begin errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, o_data, exp_d); end
                end
            end
            prev_stall = o_data_valid && !i_data_ready;
            prev_dat   = o_data;
            hold       = i_data_valid && !o_data_ready;
            step();
        end
        i_data_valid = 1'b0; i_data_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            #1;
            if (o_data_valid) begin
                exp_d = q.pop_front();
                checks++; if (o_data !== exp_d) begin errors++; $display("FAIL rand_drain got=%h exp=%h", o_data, exp_d); end
            end
            step();
        end
        checks++; if (q.size() != 0 || o_occupancy !== 4'd0) begin errors++; $display("FAIL rand_left got q=%0d occ=%0d exp 0/0", q.size(), o_occupancy); end
        checks++; if (o_pkt_count !== 32'(exp_cnt)) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", o_pkt_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
